// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// A multiply or divide takes WIDTH radix-2 iterations plus one fix-up cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  // state | meaning
  // IDLE  | waiting for Start; MTHI/MTLO complete here in one edge
  // MUL   | shift-add multiply iterations on operand magnitudes
  // DIV   | restoring divide iterations on operand magnitudes
  // FIX   | sign correction and special cases, then write HI/LO
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc, q, mb, a_r, b_r;
  logic [1:0]         op_r;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               sa, sb, div0, ovf;

  assign Busy  = (state != IDLE);

  assign mag_a = (Op[0] && A[WIDTH-1]) ? -A : A;
  assign mag_b = (Op[0] && B[WIDTH-1]) ? -B : B;

  assign mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, mb} : '0);
  assign div_sh   = {acc, q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, mb};

  assign sa       = op_r[0] & a_r[WIDTH-1];
  assign sb       = op_r[0] & b_r[WIDTH-1];
  assign prod     = {acc, q};
  assign prod_fix = (sa ^ sb) ? -prod : prod;
  assign quo_fix  = (sa ^ sb) ? -q : q;
  assign rem_fix  = sa ? -acc : acc;
  assign div0     = (b_r == '0);
  assign ovf      = op_r[0] && (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == '1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) begin
        if (Op == 3'b000 || Op == 3'b001)      state_nxt = MUL;
        else if (Op == 3'b010 || Op == 3'b011) state_nxt = DIV;
      end
      MUL, DIV: if (cnt == CW'(1)) state_nxt = FIX;
      FIX:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI   <= '0;
      LO   <= '0;
      Done <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      q    <= '0;
      mb   <= '0;
      a_r  <= '0;
      b_r  <= '0;
      op_r <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          if (!Op[2]) begin
            a_r  <= A;
            b_r  <= B;
            op_r <= Op[1:0];
            acc  <= '0;
            q    <= mag_a;
            mb   <= mag_b;
            cnt  <= CW'(WIDTH);
          end else if (Op == 3'b100) begin
            HI <= A;
          end else if (Op == 3'b101) begin
            LO <= A;
          end
        end
        MUL: begin
          acc <= mul_sum[WIDTH:1];
          q   <= {mul_sum[0], q[WIDTH-1:1]};
          cnt <= cnt - CW'(1);
        end
        DIV: begin
          // Remainder stays below the divisor, so a set top bit means the trial subtract underflowed.
          if (!div_diff[WIDTH]) begin
            acc <= div_diff[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b1};
          end else begin
            acc <= div_sh[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          Done <= 1'b1;
          if (!op_r[1]) begin
            {HI, LO} <= prod_fix;
          end else if (div0) begin
            LO <= '1;
            HI <= a_r;
          end else if (ovf) begin
            LO <= a_r;
            HI <= '0;
          end else begin
            LO <= quo_fix;
            HI <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO register width; legal values are WIDTH >= 4.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 A  input  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO source.
REQ-005 B  input  WIDTH  operand B: multiplier or divisor.
REQ-006 Op  input  3  operation select: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-007 Start  input  1  issue request; sampled only when Busy=0.
REQ-008 Busy  output  1  high while a multiply or divide is in progress.
REQ-009 Done  output  1  one-cycle pulse marking the edge at which a multiply or divide result is written.
REQ-010 HI  output  WIDTH  HI register: product upper half, or remainder.
REQ-011 LO  output  WIDTH  LO register: product lower half, or quotient.

Function
REQ-012 The block shall contain the states IDLE, MUL, DIV and FIX, plus an iteration counter sized to hold the values 0..WIDTH.
REQ-013 In IDLE, Start=1 with Op in {000,001} at edge N shall latch A, B and Op, and enter MUL.
REQ-014 In IDLE, Start=1 with Op in {010,011} at edge N shall latch A, B and Op, and enter DIV.
REQ-015 Busy shall be 1 from edge N to edge N+WIDTH+1, giving exactly WIDTH+1 Busy cycles.
REQ-016 MUL and DIV shall each run one radix-2 iteration per cycle for WIDTH cycles, on operand magnitudes for signed ops and raw operands for unsigned ops.
REQ-017 FIX shall take one cycle and shall apply sign correction and the special-case results.
REQ-018 At the edge N+WIDTH+1, HI/LO shall be written, Busy shall fall and Done shall be 1 for that one cycle.
REQ-019 The block shall return from FIX to IDLE.
REQ-020 HI/LO shall keep their previous values throughout a Busy interval.
REQ-021 Changes on A/B/Op/Start during Busy shall have no effect.
REQ-022 MULT and MULTU shall produce the full 2*WIDTH-bit product, with {HI,LO} = A*B, signed or unsigned respectively.
REQ-023 DIVU and DIV shall write LO = quotient and HI = remainder.
REQ-024 Signed division shall truncate toward zero, and the remainder shall take the sign of the dividend.
REQ-025 Divide by zero, signed or unsigned, shall write LO = all ones and HI = A, after the same WIDTH+1 latency.
REQ-026 Signed overflow (A = most-negative, B = all ones) shall write LO = A and HI = 0.
REQ-027 MTHI shall write HI = A at the edge, only in IDLE with Start=1; Busy and Done stay 0.
REQ-028 MTLO shall write LO = A at the edge, only in IDLE with Start=1; Busy and Done stay 0.
REQ-029 Start=1 with a reserved Op shall be a no-op, with no state change.
REQ-030 Start=1 on the Done edge shall be ignored, because Busy=1 during that cycle.
REQ-031 A new op shall be accepted on the first cycle in which Busy=0.
REQ-032 Back-to-back operations shall therefore be spaced WIDTH+2 cycles apart, start edge to start edge.

Reset
REQ-033 When reset=1 at an edge, the block shall force state IDLE, counter 0, Busy=0, Done=0, HI=0 and LO=0.
REQ-034 Reset shall have priority over Start.
REQ-035 Reset during MUL/DIV/FIX shall abort the operation with no Done pulse and no partial result visible on HI/LO.

Verification (WIDTH=32)
REQ-036 MULT A=0xFFFFFFFF B=0x00000002 -> Busy high 33 cycles, Done pulse, HI=0xFFFFFFFF LO=0xFFFFFFFE; the same operands with MULTU -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-037 DIV A=0xFFFFFFF9 B=0x00000002 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU A=7 B=2 -> LO=3 HI=1.
REQ-038 DIV A=5 B=0 -> LO=0xFFFFFFFF HI=0x00000005 after 33 Busy cycles; DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000 HI=0.
REQ-039 Each of the following, issued while DIVU is Busy, shall be ignored with HI/LO unchanged: MTHI A=0x1234, and Start with MULT. After Done: MTLO A=0xABCD -> LO=0x0000ABCD at the next edge, Busy stays 0, no Done.
REQ-040 Reset asserted 10 cycles into a DIV -> next cycle Busy=0 HI=0 LO=0, no Done; a fresh MULTU 3*4 then yields HI=0 LO=12.
